// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external combinational ALU between two requesters. Only one
//   operation is in flight at a time. When both requesters are valid, the
//   grant alternates between them (round-robin). Operands and opcode are
//   registered onto the ALU. The result and flags are captured one cycle
//   later and held until the owning requester accepts the response.
//
// Ports
//   CLK, Reset_n           clock, asynchronous active-low reset
//   ReqValid/ReqReady[1:0] request handshake, bit i = requester i
//   ReqA0/ReqB0/ReqOP0     requester 0 operands and opcode
//   ReqA1/ReqB1/ReqOP1     requester 1 operands and opcode
//   AluA/AluB/AluOP        registered ALU inputs
//   AluOut/AluEquals/AluLt ALU result and flags
//   RespValid/RespReady    response handshake, bit i = requester i
//   RespData/RespEquals/RespLt captured result and flags
//   Busy                   high whenever the FSM is not IDLE
//
// state | meaning
// IDLE  | waiting for a request; ReqReady may assert only here
// EXEC  | ALU inputs are stable; result is captured at the end of the cycle
// HOLD  | response is presented to the owner until RespReady[owner]

module alu_arbiter #(
  parameter int W   = 8,
  parameter int OPW = 3
) (
  input  logic           CLK,
  input  logic           Reset_n,
  input  logic [1:0]     ReqValid,
  output logic [1:0]     ReqReady,
  input  logic [W-1:0]   ReqA0,
  input  logic [W-1:0]   ReqB0,
  input  logic [OPW-1:0] ReqOP0,
  input  logic [W-1:0]   ReqA1,
  input  logic [W-1:0]   ReqB1,
  input  logic [OPW-1:0] ReqOP1,
  output logic [W-1:0]   AluA,
  output logic [W-1:0]   AluB,
  output logic [OPW-1:0] AluOP,
  input  logic [W-1:0]   AluOut,
  input  logic           AluEquals,
  input  logic           AluLt,
  output logic [1:0]     RespValid,
  input  logic [1:0]     RespReady,
  output logic [W-1:0]   RespData,
  output logic           RespEquals,
  output logic           RespLt,
  output logic           Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_grant_q, last_grant_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [W-1:0]   resp_data_q, resp_data_d;
  logic           resp_eq_q, resp_eq_d;
  logic           resp_lt_q, resp_lt_d;

  logic           grant;
  logic           accept;

  // On a tie, the requester that did not win last time wins now. Otherwise
  // the single valid requester wins.
  always_comb begin
    grant = ReqValid[1];
    if (ReqValid == 2'b11) begin
      grant = ~last_grant_q;
    end
  end

  always_comb begin
    ReqReady = 2'b00;
    if (state_q == IDLE && ReqValid != 2'b00) begin
      ReqReady = grant ? 2'b10 : 2'b01;
    end
  end

  assign accept = |(ReqValid & ReqReady);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    resp_data_d  = resp_data_q;
    resp_eq_d    = resp_eq_q;
    resp_lt_d    = resp_lt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = grant;
          last_grant_d = grant;
          alu_a_d      = grant ? ReqA1  : ReqA0;
          alu_b_d      = grant ? ReqB1  : ReqB0;
          alu_op_d     = grant ? ReqOP1 : ReqOP0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        resp_data_d = AluOut;
        resp_eq_d   = AluEquals;
        resp_lt_d   = AluLt;
        state_d     = HOLD;
      end
      HOLD: begin
        // Only the owner's RespReady is looked at.
        if (RespReady[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      resp_data_q  <= '0;
      resp_eq_q    <= 1'b0;
      resp_lt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      resp_data_q  <= resp_data_d;
      resp_eq_q    <= resp_eq_d;
      resp_lt_q    <= resp_lt_d;
    end
  end

  // RespValid is decoded from the state register, so an asynchronous reset
  // clears it at once without waiting for a clock edge.
  always_comb begin
    RespValid = 2'b00;
    if (state_q == HOLD) begin
      RespValid = owner_q ? 2'b10 : 2'b01;
    end
  end

  assign Busy       = (state_q != IDLE);
  assign AluA       = alu_a_q;
  assign AluB       = alu_b_q;
  assign AluOP      = alu_op_q;
  assign RespData   = resp_data_q;
  assign RespEquals = resp_eq_q;
  assign RespLt     = resp_lt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a behavioural ALU drives the shared ALU port.
// Expected grants and responses come from a round-robin/arithmetic model
// of the arbiter's rules.
module tb_alu_arbiter;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2,
                         OP_OR  = 3'd3, OP_XOR = 3'd4, OP_LSL = 3'd5,
                         OP_LSR = 3'd6, OP_PSA = 3'd7;

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic [1:0] ReqValid = 2'b00;
  logic [1:0] ReqReady;
  logic [7:0] ReqA0 = 8'h00, ReqB0 = 8'h00, ReqA1 = 8'h00, ReqB1 = 8'h00;
  logic [2:0] ReqOP0 = 3'd0, ReqOP1 = 3'd0;
  logic [7:0] AluA, AluB, AluOut;
  logic [2:0] AluOP;
  logic       AluEquals, AluLt;
  logic [1:0] RespValid;
  logic [1:0] RespReady = 2'b00;
  logic [7:0] RespData;
  logic       RespEquals, RespLt, Busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_g = 1;
  int prev_acc = -1;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [7:0] alu_ref(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_LSL:  return a << b[2:0];
      OP_LSR:  return a >> b[2:0];
      default: return a;
    endcase
  endfunction

  always_comb begin
    AluOut    = alu_ref(AluOP, AluA, AluB);
    AluEquals = (AluA == AluB);
    AluLt     = (AluA < AluB);
  end

  alu_arbiter #(.W(8), .OPW(3)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqOP0(ReqOP0),
    .ReqA1(ReqA1), .ReqB1(ReqB1), .ReqOP1(ReqOP1),
    .AluA(AluA), .AluB(AluB), .AluOP(AluOP),
    .AluOut(AluOut), .AluEquals(AluEquals), .AluLt(AluLt),
    .RespValid(RespValid), .RespReady(RespReady),
    .RespData(RespData), .RespEquals(RespEquals), .RespLt(RespLt),
    .Busy(Busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete transaction from IDLE back to IDLE. The grant and the
  // response are predicted from the request pattern and the arithmetic model.
  task automatic do_op(input logic [1:0] v,
                       input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] o0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] o1,
                       input int stall, input bit keep, input bit spacing,
                       input string tag);
    int g;
    logic [7:0] ea, eb, er;
    logic [2:0] eo;
    ReqA0 = a0; ReqB0 = b0; ReqOP0 = o0;
    ReqA1 = a1; ReqB1 = b1; ReqOP1 = o1;
    ReqValid = v;
    RespReady = 2'b00;
    #1;
    g  = (v == 2'b11) ? (1 - last_g) : (v[1] ? 1 : 0);
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    eo = g ? o1 : o0;
    er = alu_ref(eo, ea, eb);
    chk({tag, ".req_ready"}, 16'(ReqReady), 16'(2'b01 << g));
    chk({tag, ".idle_busy"}, 16'(Busy), 16'd0);
    tick();
    if (spacing && prev_acc >= 0) chk({tag, ".spacing"}, 16'(cyc - prev_acc), 16'd3);
    prev_acc = cyc;
    chk({tag, ".exec_busy"}, 16'(Busy), 16'd1);
    chk({tag, ".exec_ready"}, 16'(ReqReady), 16'd0);
    chk({tag, ".alu_a"}, 16'(AluA), 16'(ea));
    chk({tag, ".alu_b"}, 16'(AluB), 16'(eb));
    chk({tag, ".alu_op"}, 16'(AluOP), 16'(eo));
    if (!keep) ReqValid = 2'b00;
    RespReady = (stall > 0) ? (2'b11 & ~(2'b01 << g)) : 2'b11;
    tick();
    chk({tag, ".resp_valid"}, 16'(RespValid), 16'(2'b01 << g));
    chk({tag, ".resp_data"}, 16'(RespData), 16'(er));
    chk({tag, ".resp_eq"}, 16'(RespEquals), 16'(ea == eb));
    chk({tag, ".resp_lt"}, 16'(RespLt), 16'(ea < eb));
    chk({tag, ".hold_ready"}, 16'(ReqReady), 16'd0);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk({tag, ".stall_valid"}, 16'(RespValid), 16'(2'b01 << g));
      chk({tag, ".stall_data"}, 16'(RespData), 16'(er));
      chk({tag, ".stall_ready"}, 16'(ReqReady), 16'd0);
    end
    RespReady = 2'b11;
    tick();
    last_g = g;
    chk({tag, ".done_valid"}, 16'(RespValid), 16'd0);
    chk({tag, ".done_busy"}, 16'(Busy), 16'd0);
    RespReady = 2'b00;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst.alu_a", 16'(AluA), 16'd0);
    chk("rst.alu_b", 16'(AluB), 16'd0);
    chk("rst.alu_op", 16'(AluOP), 16'd0);
    chk("rst.resp_valid", 16'(RespValid), 16'd0);
    chk("rst.req_ready", 16'(ReqReady), 16'd0);
    chk("rst.resp_data", 16'(RespData), 16'd0);
    chk("rst.flags", 16'({RespEquals, RespLt}), 16'd0);
    chk("rst.busy", 16'(Busy), 16'd0);
    @(negedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;
    tick();

    // Directed operations
    do_op(2'b01, 8'h05, 8'h03, OP_ADD, 8'h00, 8'h00, OP_ADD, 0, 0, 0, "add");
    do_op(2'b10, 8'h00, 8'h00, OP_ADD, 8'h2A, 8'h2A, OP_SUB, 0, 0, 0, "sub_eq");
    do_op(2'b10, 8'h00, 8'h00, OP_ADD, 8'hF0, 8'h0F, OP_XOR, 0, 0, 0, "xor");
    do_op(2'b01, 8'h81, 8'h01, OP_LSL, 8'h00, 8'h00, OP_ADD, 0, 0, 0, "lsl");

    // Tie and fairness: both held valid, back-to-back with 3-cycle spacing
    prev_acc = -1;
    for (int k = 0; k < 6; k++) begin
      do_op(2'b11, 8'(8'h10 + k), 8'(8'h03 * k), OP_ADD,
            8'(8'h40 + k), 8'(k), OP_SUB, 0, 1, 1, "fair");
    end
    ReqValid = 2'b00;
    tick();

    // Reset during EXEC
    ReqA0 = 8'h11; ReqB0 = 8'h22; ReqOP0 = OP_OR; ReqValid = 2'b01;
    tick();
    chk("rst_exec.busy_before", 16'(Busy), 16'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_exec.busy", 16'(Busy), 16'd0);
    chk("rst_exec.alu_a", 16'(AluA), 16'd0);
    chk("rst_exec.resp_valid", 16'(RespValid), 16'd0);
    ReqValid = 2'b00;
    @(negedge CLK);
    Reset_n = 1'b1;
    tick();
    tick();
    chk("rst_exec.no_resp", 16'(RespValid), 16'd0);

    // Reset during HOLD
    ReqA1 = 8'h33; ReqB1 = 8'h01; ReqOP1 = OP_ADD; ReqValid = 2'b10;
    tick();
    ReqValid = 2'b00;
    tick();
    chk("rst_hold.valid_before", 16'(RespValid), 16'b10);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_hold.resp_valid", 16'(RespValid), 16'd0);
    chk("rst_hold.resp_data", 16'(RespData), 16'd0);
    @(negedge CLK);
    Reset_n = 1'b1;
    tick();
    tick();
    chk("rst_hold.no_resp", 16'(RespValid), 16'd0);
    last_g = 1;

    // Backpressure: next tie must go to requester 0, then to requester 1
    do_op(2'b11, 8'hCC, 8'hAA, OP_AND, 8'h01, 8'h02, OP_ADD, 5, 1, 0, "bp0");
    do_op(2'b11, 8'hCC, 8'hAA, OP_AND, 8'h01, 8'h02, OP_ADD, 0, 0, 0, "bp1");

    // Randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      do_op(2'($urandom_range(1, 3)),
            8'($urandom), 8'($urandom), 3'($urandom),
            8'($urandom), 8'($urandom), 3'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom), 0, "rand");
    end
    ReqValid = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
